// File: rtl/window_gen_lb.sv
// window_gen_lb: streaming KxK multi-channel window generator with K-1
// internal line buffers. It accepts one raster-order pixel per cycle and
// emits a full 2-D neighbourhood for every interior pixel (valid-only border:
// no padding, so windows never cross a line wrap or a frame boundary).
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_valid    : pixel accepted on this edge
//   in_sof      : start of frame; forces the accepted pixel to (0,0)
//   in_data     : CH*PIX_W pixel, channel c at [c*PIX_W +: PIX_W]
//   out_valid   : one-cycle pulse, window/coords valid
//   out_window  : K*K*CH*PIX_W; element (r,c,ch) at ((r*K+c)*CH+ch)*PIX_W,
//                 r=0 oldest line, c=0 oldest column
//   out_x/out_y : window centre coordinates
//   out_eof     : high with the last window of a frame

// One line of storage. Combinational read, so a read and a write at the same
// address in the same cycle return the old contents (read-before-write).
module wgl_line #(
  parameter int W     = 24,
  parameter int DEPTH = 640,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout
);
  // Contents are deliberately not reset; stale data is never emitted.
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[addr] <= din;

  assign dout = mem[addr];
endmodule

module window_gen_lb #(
  parameter int PIX_W = 8,
  parameter int CH    = 3,
  parameter int K     = 3,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic                     in_sof,
  input  logic [CH*PIX_W-1:0]      in_data,
  output logic                     out_valid,
  output logic [K*K*CH*PIX_W-1:0]  out_window,
  output logic [15:0]              out_x,
  output logic [15:0]              out_y,
  output logic                     out_eof
);
  localparam int PXW  = CH*PIX_W;
  localparam int NL   = K-1;
  localparam int HALF = (K-1)/2;
  localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [CW-1:0] col, eff_col;
  logic [RW-1:0] row, eff_row;
  logic          accept, last_col, last_row, qual;

  logic [NL-1:0][PXW-1:0]         lb_din, lb_dout;
  logic [K-1:0][PXW-1:0]          col_new;
  logic [K-1:0][K-1:0][PXW-1:0]   win;

  assign accept = in_valid;

  // in_sof resynchronises: the accepted pixel is (0,0) whatever the counters say.
  assign eff_col  = in_sof ? '0 : col;
  assign eff_row  = in_sof ? '0 : row;
  assign last_col = (eff_col == CW'(IMG_W-1));
  assign last_row = (eff_row == RW'(IMG_H-1));

  // Only fully interior positions of the current frame qualify; since all
  // K-1 previous lines of this frame were written at every column, nothing
  // from an earlier frame or an earlier line can reach the window.
  assign qual = accept && (int'(eff_col) >= K-1) && (int'(eff_row) >= K-1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : eff_row + RW'(1);
      end else begin
        col <= eff_col + CW'(1);
        row <= eff_row;
      end
    end
  end

  // Line buffer chain: buffer 0 takes the incoming pixel, buffer j takes the
  // value buffer j-1 held at this column before the write.
  always_comb begin
    lb_din[0] = in_data;
    for (int j = 1; j < NL; j++) lb_din[j] = lb_dout[j-1];
  end

  for (genvar j = 0; j < NL; j++) begin : g_lb
    wgl_line #(.W(PXW), .DEPTH(IMG_W), .AW(CW)) u_line (
      .clk  (clk),
      .we   (accept),
      .addr (eff_col),
      .din  (lb_din[j]),
      .dout (lb_dout[j])
    );
  end

  // New rightmost column, top (oldest line) to bottom (incoming pixel).
  always_comb begin
    col_new[K-1] = in_data;
    for (int r = 0; r < K-1; r++) col_new[r] = lb_dout[K-2-r];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win <= '0;
    end else if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K-1; c++) win[r][c] <= win[r][c+1];
        win[r][K-1] <= col_new[r];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_eof   <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
    end else begin
      out_valid <= qual;
      out_eof   <= qual && last_col && last_row;
      if (qual) begin
        out_x <= 16'(eff_col) - 16'(HALF);
        out_y <= 16'(eff_row) - 16'(HALF);
      end
    end
  end

  // The window register is itself registered and shifts only on accepted
  // pixels, so it holds whenever in_valid is low.
  assign out_window = win;
endmodule
